// File: rtl/controle_ula_pkg.sv
// Shared definitions for the ALU sequencing front-end.
//   - ALU opcode constants (4-bit command field)
//   - controller state enum
//   - all-ones result returned on divide/modulo by zero
package controle_ula_pkg;

   localparam int unsigned LARGURA_COMANDO = 4;

   // Widest operand width the error constant covers; LARGURA must not exceed it.
   localparam int unsigned LARGURA_MAX = 64;

   localparam logic [LARGURA_COMANDO-1:0] OP_SOMA    = 4'h0;
   localparam logic [LARGURA_COMANDO-1:0] OP_SUB     = 4'h1;
   localparam logic [LARGURA_COMANDO-1:0] OP_MUL     = 4'h2;
   localparam logic [LARGURA_COMANDO-1:0] OP_DIV     = 4'h3;
   localparam logic [LARGURA_COMANDO-1:0] OP_MOD     = 4'h4;
   localparam logic [LARGURA_COMANDO-1:0] OP_E       = 4'h5;
   localparam logic [LARGURA_COMANDO-1:0] OP_OU      = 4'h6;
   localparam logic [LARGURA_COMANDO-1:0] OP_NAO     = 4'h7;
   localparam logic [LARGURA_COMANDO-1:0] OP_XOU     = 4'h8;
   localparam logic [LARGURA_COMANDO-1:0] OP_SHR     = 4'h9;
   localparam logic [LARGURA_COMANDO-1:0] OP_SHL     = 4'hA;
   localparam logic [LARGURA_COMANDO-1:0] OP_IGUAL   = 4'hB;
   localparam logic [LARGURA_COMANDO-1:0] OP_MAIOR   = 4'hC;
   localparam logic [LARGURA_COMANDO-1:0] OP_MENOR   = 4'hD;
   localparam logic [LARGURA_COMANDO-1:0] OP_PASSA_B = 4'hE;
   localparam logic [LARGURA_COMANDO-1:0] OP_PASSA_A = 4'hF;

   typedef enum logic [1:0] {
      EstOcioso,
      EstExecuta,
      EstResposta
   } estado_t;

   localparam logic [LARGURA_MAX-1:0] RESULTADO_ERRO = '1;

endpackage

// File: rtl/controle_ula.sv
// Sequencing front-end for the ALU.
// Accepts a request (command, A, B, tag) over valid/ready, drives the registered
// command/operands into the external ALU, captures the ALU result and zero flag one
// cycle later into a one-entry response buffer, and counts responses taken.
// Ports:
//   clock, reset_n                   clock, async active-low reset
//   req_valido/req_pronto            request handshake
//   req_comando, req_a, req_b, req_tag  request payload
//   ula_comando, ula_entrada1/2      command and operands to the ALU
//   ula_saida, ula_zeroflag          ALU result and zero flag (combinational)
//   resp_valido/resp_pronto          response handshake
//   resp_resultado, resp_zero, resp_erro, resp_tag  response payload
//   contador_ops                     number of responses taken, wraps
module controle_ula
   import controle_ula_pkg::*;
#(
   parameter int unsigned LARGURA = 32,
   parameter int unsigned TAG_W   = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       req_valido,
   output logic                       req_pronto,
   input  logic [LARGURA_COMANDO-1:0] req_comando,
   input  logic [LARGURA-1:0]         req_a,
   input  logic [LARGURA-1:0]         req_b,
   input  logic [TAG_W-1:0]           req_tag,
   output logic [LARGURA_COMANDO-1:0] ula_comando,
   output logic [LARGURA-1:0]         ula_entrada1,
   output logic [LARGURA-1:0]         ula_entrada2,
   input  logic [LARGURA-1:0]         ula_saida,
   input  logic                       ula_zeroflag,
   output logic                       resp_valido,
   input  logic                       resp_pronto,
   output logic [LARGURA-1:0]         resp_resultado,
   output logic                       resp_zero,
   output logic                       resp_erro,
   output logic [TAG_W-1:0]           resp_tag,
   output logic [15:0]                contador_ops
);

   estado_t                    estado_q, estado_d;
   logic [LARGURA_COMANDO-1:0] cmd_q;
   logic [LARGURA-1:0]         a_q, b_q;
   logic [TAG_W-1:0]           tag_q;
   logic [LARGURA-1:0]         resultado_q;
   logic                       zero_q, erro_q;
   logic [15:0]                contador_q;

   logic req_ok, resp_ok, erro_div;

   assign req_ok  = req_valido && req_pronto;
   assign resp_ok = resp_valido && resp_pronto;

   // Divide/modulo by zero: the ALU is asked for a harmless pass-B instead.
   assign erro_div = ((cmd_q == OP_DIV) || (cmd_q == OP_MOD)) && (b_q == '0);

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= EstOcioso;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Next state
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         EstOcioso:   if (req_ok) estado_d = EstExecuta;
         EstExecuta:  estado_d = EstResposta;
         EstResposta: if (resp_ok) estado_d = req_ok ? EstExecuta : EstOcioso;
         default:     estado_d = EstOcioso;
      endcase
   end

   // Outputs; RESPOSTA accepts only when the buffered response drains this cycle.
   always_comb begin
      req_pronto  = 1'b0;
      resp_valido = 1'b0;
      case (estado_q)
         EstOcioso:   req_pronto = 1'b1;
         EstResposta: begin
            req_pronto  = resp_pronto;
            resp_valido = 1'b1;
         end
         default: ;
      endcase
   end

   // Request registers: stable until the next accept.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cmd_q <= OP_SOMA;
         a_q   <= '0;
         b_q   <= '0;
         tag_q <= '0;
      end else if (req_ok) begin
         cmd_q <= req_comando;
         a_q   <= req_a;
         b_q   <= req_b;
         tag_q <= req_tag;
      end
   end

   // Response capture on the EXECUTA -> RESPOSTA edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         resultado_q <= '0;
         zero_q      <= 1'b0;
         erro_q      <= 1'b0;
      end else if (estado_q == EstExecuta) begin
         if (erro_div) begin
            resultado_q <= RESULTADO_ERRO[LARGURA-1:0];
            zero_q      <= 1'b0;
            erro_q      <= 1'b1;
         end else begin
            resultado_q <= ula_saida;
            zero_q      <= ula_zeroflag;
            erro_q      <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         contador_q <= '0;
      end else if (resp_ok) begin
         contador_q <= contador_q + 16'd1;
      end
   end

   assign ula_comando    = erro_div ? OP_PASSA_B : cmd_q;
   assign ula_entrada1   = a_q;
   assign ula_entrada2   = b_q;
   assign resp_resultado = resultado_q;
   assign resp_zero      = zero_q;
   assign resp_erro      = erro_q;
   // tag_q cannot change while a response is held, so it doubles as the response tag.
   assign resp_tag       = tag_q;
   assign contador_ops   = contador_q;

endmodule

// File: tb/tb_controle_ula.sv
// Directed testbench for controle_ula with a small behavioural ALU beside it.
module tb_controle_ula;
   import controle_ula_pkg::*;

   localparam int unsigned LARGURA = 32;
   localparam int unsigned TAG_W   = 4;

   logic                       clock = 1'b0;
   logic                       reset_n;
   logic                       req_valido;
   logic                       req_pronto;
   logic [LARGURA_COMANDO-1:0] req_comando;
   logic [LARGURA-1:0]         req_a, req_b;
   logic [TAG_W-1:0]           req_tag;
   logic [LARGURA_COMANDO-1:0] ula_comando;
   logic [LARGURA-1:0]         ula_entrada1, ula_entrada2;
   logic [LARGURA-1:0]         ula_saida;
   logic                       ula_zeroflag;
   logic                       resp_valido;
   logic                       resp_pronto;
   logic [LARGURA-1:0]         resp_resultado;
   logic                       resp_zero, resp_erro;
   logic [TAG_W-1:0]           resp_tag;
   logic [15:0]                contador_ops;

   int n_verif  = 0;
   int n_falhas = 0;

   always #5 clock = ~clock;

   controle_ula #(
      .LARGURA (LARGURA),
      .TAG_W   (TAG_W)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_valido     (req_valido),
      .req_pronto     (req_pronto),
      .req_comando    (req_comando),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_tag        (req_tag),
      .ula_comando    (ula_comando),
      .ula_entrada1   (ula_entrada1),
      .ula_entrada2   (ula_entrada2),
      .ula_saida      (ula_saida),
      .ula_zeroflag   (ula_zeroflag),
      .resp_valido    (resp_valido),
      .resp_pronto    (resp_pronto),
      .resp_resultado (resp_resultado),
      .resp_zero      (resp_zero),
      .resp_erro      (resp_erro),
      .resp_tag       (resp_tag),
      .contador_ops   (contador_ops)
   );

   // Stand-in ALU. eq returns 1 on match and B otherwise; the zero flag reports the
   // match for eq and result==0 for everything else.
   always_comb begin
      ula_saida = '0;
      case (ula_comando)
         OP_SOMA:    ula_saida = ula_entrada1 + ula_entrada2;
         OP_SUB:     ula_saida = ula_entrada1 - ula_entrada2;
         OP_MUL:     ula_saida = ula_entrada1 * ula_entrada2;
         OP_DIV:     ula_saida = (ula_entrada2 != 0) ? ula_entrada1 / ula_entrada2 : '0;
         OP_MOD:     ula_saida = (ula_entrada2 != 0) ? ula_entrada1 % ula_entrada2 : '0;
         OP_E:       ula_saida = ula_entrada1 & ula_entrada2;
         OP_OU:      ula_saida = ula_entrada1 | ula_entrada2;
         OP_NAO:     ula_saida = ~ula_entrada1;
         OP_XOU:     ula_saida = ula_entrada1 ^ ula_entrada2;
         OP_SHR:     ula_saida = ula_entrada1 >> ula_entrada2;
         OP_SHL:     ula_saida = ula_entrada1 << ula_entrada2;
         OP_IGUAL:   ula_saida = (ula_entrada1 == ula_entrada2) ? 32'd1 : ula_entrada2;
         OP_MAIOR:   ula_saida = {31'd0, ula_entrada1 > ula_entrada2};
         OP_MENOR:   ula_saida = {31'd0, ula_entrada1 < ula_entrada2};
         OP_PASSA_B: ula_saida = ula_entrada2;
         default:    ula_saida = ula_entrada1;
      endcase
      ula_zeroflag = (ula_comando == OP_IGUAL) ? (ula_entrada1 == ula_entrada2)
                                               : (ula_saida == '0);
   end

   task automatic verifica(input string tag, input logic [63:0] obtido,
                           input logic [63:0] esperado);
      n_verif++;
      if (obtido !== esperado) begin
         n_falhas++;
         $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado);
      end
   endtask

   // Present a request at a falling edge; it transfers on the next rising edge.
   task automatic aceita(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
      @(negedge clock);
      req_valido  = 1'b1;
      req_comando = cmd;
      req_a       = a;
      req_b       = b;
      req_tag     = tag;
      #1 verifica("aceita_req_pronto", req_pronto, 1'b1);
      @(posedge clock);
      #1 req_valido = 1'b0;
   endtask

   // Accept, then check the EXECUTA cycle and the response one edge later.
   task automatic executa(input string nome, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag,
                          input logic [3:0] cmd_ula, input logic [31:0] res,
                          input logic zero, input logic erro);
      aceita(cmd, a, b, tag);
      @(negedge clock);
      verifica({nome, "_exec_valido"}, resp_valido, 1'b0);
      verifica({nome, "_exec_pronto"}, req_pronto, 1'b0);
      verifica({nome, "_ula_comando"}, ula_comando, cmd_ula);
      verifica({nome, "_ula_a"}, ula_entrada1, a);
      verifica({nome, "_ula_b"}, ula_entrada2, b);
      @(negedge clock);
      verifica({nome, "_resp_valido"}, resp_valido, 1'b1);
      verifica({nome, "_resultado"}, resp_resultado, res);
      verifica({nome, "_zero"}, resp_zero, zero);
      verifica({nome, "_erro"}, resp_erro, erro);
      verifica({nome, "_tag"}, resp_tag, tag);
   endtask

   // Called at a falling edge with a response held; drains it.
   task automatic drena(input string nome, input logic [15:0] cont);
      resp_pronto = 1'b1;
      #1 verifica({nome, "_drena_req_pronto"}, req_pronto, 1'b1);
      @(posedge clock);
      #1 resp_pronto = 1'b0;
      @(negedge clock);
      verifica({nome, "_drena_valido"}, resp_valido, 1'b0);
      verifica({nome, "_contador"}, contador_ops, cont);
   endtask

   initial begin
      reset_n     = 1'b0;
      req_valido  = 1'b0;
      req_comando = '0;
      req_a       = '0;
      req_b       = '0;
      req_tag     = '0;
      resp_pronto = 1'b0;

      #12;
      verifica("rst_req_pronto", req_pronto, 1'b1);
      verifica("rst_resp_valido", resp_valido, 1'b0);
      verifica("rst_ula_comando", ula_comando, 4'h0);
      verifica("rst_resultado", resp_resultado, 32'd0);
      verifica("rst_contador", contador_ops, 16'd0);
      @(negedge clock);
      reset_n = 1'b1;

      executa("soma", OP_SOMA, 32'd7, 32'd5, 4'h1, OP_SOMA, 32'd12, 1'b0, 1'b0);
      drena("soma", 16'd1);

      executa("div0", OP_DIV, 32'd9, 32'd0, 4'h2, OP_PASSA_B, 32'hFFFF_FFFF, 1'b0, 1'b1);
      drena("div0", 16'd2);
      executa("mod0", OP_MOD, 32'd9, 32'd0, 4'h3, OP_PASSA_B, 32'hFFFF_FFFF, 1'b0, 1'b1);
      drena("mod0", 16'd3);

      executa("igual", OP_IGUAL, 32'h55, 32'h55, 4'h4, OP_IGUAL, 32'd1, 1'b1, 1'b0);
      drena("igual", 16'd4);
      executa("difer", OP_IGUAL, 32'd1, 32'd2, 4'h5, OP_IGUAL, 32'd2, 1'b0, 1'b0);
      drena("difer", 16'd5);

      // Backpressure: a stray request while the response is held must be ignored.
      executa("sub", OP_SUB, 32'd20, 32'd6, 4'h9, OP_SUB, 32'd14, 1'b0, 1'b0);
      req_valido  = 1'b1;
      req_comando = OP_MUL;
      req_a       = 32'd3;
      req_b       = 32'd3;
      req_tag     = 4'hE;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         verifica("bp_valido", resp_valido, 1'b1);
         verifica("bp_req_pronto", req_pronto, 1'b0);
         verifica("bp_resultado", resp_resultado, 32'd14);
         verifica("bp_tag", resp_tag, 4'h9);
         verifica("bp_ula_comando", ula_comando, OP_SUB);
      end
      // Release together with a new request: drain and accept on the same edge.
      resp_pronto = 1'b1;
      req_comando = OP_XOU;
      req_a       = 32'hF0;
      req_b       = 32'hFF;
      req_tag     = 4'h3;
      #1 verifica("bp_libera_req_pronto", req_pronto, 1'b1);
      @(posedge clock);
      #1;
      resp_pronto = 1'b0;
      req_valido  = 1'b0;
      @(negedge clock);
      verifica("bp_exec_valido", resp_valido, 1'b0);
      verifica("bp_contador", contador_ops, 16'd6);
      verifica("bp_ula_xou", ula_comando, OP_XOU);
      @(negedge clock);
      verifica("xou_valido", resp_valido, 1'b1);
      verifica("xou_resultado", resp_resultado, 32'h0F);
      verifica("xou_tag", resp_tag, 4'h3);
      drena("xou", 16'd7);

      // Reset while in EXECUTA.
      aceita(OP_SOMA, 32'd1, 32'd1, 4'h5);
      #2 reset_n = 1'b0;
      #1;
      verifica("rexec_req_pronto", req_pronto, 1'b1);
      verifica("rexec_valido", resp_valido, 1'b0);
      verifica("rexec_ula_comando", ula_comando, 4'h0);
      verifica("rexec_ula_a", ula_entrada1, 32'd0);
      verifica("rexec_ula_b", ula_entrada2, 32'd0);
      verifica("rexec_resultado", resp_resultado, 32'd0);
      verifica("rexec_tag", resp_tag, 4'h0);
      verifica("rexec_contador", contador_ops, 16'd0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         verifica("rexec_sem_resp", resp_valido, 1'b0);
      end

      // Counter wrap: preload near the top, then two more responses.
      @(negedge clock);
      force dut.contador_q = 16'hFFFE;
      #1 release dut.contador_q;
      executa("passa_a", OP_PASSA_A, 32'h1234, 32'd7, 4'h2, OP_PASSA_A, 32'h1234, 1'b0, 1'b0);
      drena("passa_a", 16'hFFFF);
      executa("shl", OP_SHL, 32'd1, 32'd40, 4'h6, OP_SHL, 32'd1 << 40, 1'b1, 1'b0);
      drena("wrap", 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
      $finish;
   end

endmodule
